// File: rtl/uart_program_loader.sv
// ============================================================================
// uart_program_loader: 8N1 UART boot loader driving the memory programming port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_program_loader #(
  parameter int         CLKS_PER_BIT   = 868,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       uart_rx,
  output logic       programming_enable,
  output logic [7:0] ProgrammingAddress,
  output logic [7:0] ProgrammingData,
  output logic       load_done,
  output logic       load_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] c_bit_last  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_half_last = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [GW-1:0] c_gap_last  = GW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH} rx_state_t;
  typedef enum logic [1:0] {WAIT_SYNC, WAIT_LEN, LOAD, FLUSH} ld_state_t;

  logic          sync1_q, sync2_q;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ferr_q, rx_ferr_d;

  ld_state_t     state_q, state_d;
  logic [8:0]    count_q, count_d;
  logic [7:0]    index_q, index_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          flush_q, flush_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          in_frame;
  logic          abort;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_state_q <= R_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      sync1_q    <= uart_rx;
      sync2_q    <= sync1_q;
      rx_state_q <= rx_state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    tick_d     = tick_q + CW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_state_q)
      R_IDLE: begin
        tick_d = '0;
        if (!sync2_q) rx_state_d = R_START;
      end
      R_START: begin
        if (tick_q == c_half_last) begin
          tick_d     = '0;
          bit_d      = '0;
          rx_state_d = sync2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (tick_q == c_bit_last) begin
          tick_d  = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (tick_q == c_bit_last) begin
          tick_d     = '0;
          rx_valid_d = sync2_q;
          rx_ferr_d  = !sync2_q;
          rx_state_d = sync2_q ? R_IDLE : R_WAIT_HIGH;
        end
      end
      R_WAIT_HIGH: begin
        tick_d = '0;
        if (sync2_q) rx_state_d = R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q <= WAIT_SYNC;
      count_q <= '0;
      index_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      done_q  <= done_d;
      err_q   <= err_d;
      flush_q <= flush_d;
      gap_q   <= gap_d;
    end
  end

  assign in_frame = (state_q == WAIT_LEN) || (state_q == LOAD);
  // Abort outranks a simultaneous final byte because it is tested first below.
  assign abort    = in_frame && (rx_ferr_q || (gap_q == c_gap_last));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    addr_d  = addr_q;
    data_d  = data_q;
    en_d    = en_q;
    done_d  = 1'b0;
    err_d   = err_q;
    flush_d = flush_q;
    gap_d   = in_frame ? gap_q + GW'(1) : '0;
    unique case (state_q)
      WAIT_SYNC: begin
        if (rx_valid_q && (shift_q == SYNC_BYTE)) begin
          state_d = WAIT_LEN;
          err_d   = 1'b0;
        end
      end
      WAIT_LEN: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = WAIT_SYNC;
        end else if (rx_valid_q) begin
          count_d = (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
          index_d = '0;
          gap_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = WAIT_SYNC;
        end else if (rx_valid_q) begin
          data_d  = shift_q;
          addr_d  = index_q;
          en_d    = 1'b1;
          index_d = index_q + 8'd1;
          count_d = count_q - 9'd1;
          gap_d   = '0;
          if (count_q == 9'd1) begin
            flush_d = 1'b0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (flush_q) begin
          en_d    = 1'b0;
          done_d  = 1'b1;
          state_d = WAIT_SYNC;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  assign programming_enable = en_q;
  assign ProgrammingAddress = addr_q;
  assign ProgrammingData    = data_q;
  assign load_done          = done_q;
  assign load_error         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_program_loader.sv
// ============================================================================
// tb_uart_program_loader: directed bench for the UART program loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_program_loader;

  localparam int CPB = 8;

  logic       clk;
  logic       rst_in;
  logic       uart_rx;
  logic       programming_enable;
  logic [7:0] ProgrammingAddress;
  logic [7:0] ProgrammingData;
  logic       load_done;
  logic       load_error;

  int checks = 0;
  int errors = 0;

  uart_program_loader #(
    .CLKS_PER_BIT  (CPB),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk               (clk),
    .rst_in            (rst_in),
    .uart_rx           (uart_rx),
    .programming_enable(programming_enable),
    .ProgrammingAddress(ProgrammingAddress),
    .ProgrammingData   (ProgrammingData),
    .load_done         (load_done),
    .load_error        (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame occupies 10*CPB cycles; returns one tick past the stop bit end.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop;
    tick(CPB);
  endtask

  task automatic check_pair(input string tag, input logic [7:0] a, input logic [7:0] d);
    check({tag, "_en"},   {15'd0, programming_enable}, 16'd1);
    check({tag, "_addr"}, {8'd0, ProgrammingAddress}, {8'd0, a});
    check({tag, "_data"}, {8'd0, ProgrammingData},    {8'd0, d});
    check({tag, "_done"}, {15'd0, load_done},         16'd0);
  endtask

  task automatic check_release(input string tag, input logic [7:0] a, input logic [7:0] d);
    tick(1);
    check_pair({tag, "_hold"}, a, d);
    tick(1);
    check({tag, "_en_fall"}, {15'd0, programming_enable}, 16'd0);
    check({tag, "_done"},    {15'd0, load_done},          16'd1);
    check({tag, "_err"},     {15'd0, load_error},         16'd0);
    tick(1);
    check({tag, "_done_end"}, {15'd0, load_done}, 16'd0);
  endtask

  initial begin
    rst_in  = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en",   {15'd0, programming_enable}, 16'd0);
    check("rst_addr", {8'd0, ProgrammingAddress},  16'd0);
    check("rst_data", {8'd0, ProgrammingData},     16'd0);
    check("rst_done", {15'd0, load_done},          16'd0);
    check("rst_err",  {15'd0, load_error},         16'd0);
    rst_in = 1'b0;
    tick(5);

    // Basic three-byte image
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    check("t1_no_early_en", {15'd0, programming_enable}, 16'd0);
    send_byte(8'h11, 1'b1);
    check_pair("t1_p0", 8'h00, 8'h11);
    send_byte(8'h22, 1'b1);
    check_pair("t1_p1", 8'h01, 8'h22);
    send_byte(8'h33, 1'b1);
    check_pair("t1_p2", 8'h02, 8'h33);
    check_release("t1_rel", 8'h02, 8'h33);

    // Bytes before sync are ignored
    send_byte(8'h5A, 1'b1);
    check("t2_5a_en", {15'd0, programming_enable}, 16'd0);
    send_byte(8'h00, 1'b1);
    check("t2_00_en", {15'd0, programming_enable}, 16'd0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    check("t2_len_en", {15'd0, programming_enable}, 16'd0);
    send_byte(8'hFF, 1'b1);
    check_pair("t2_p0", 8'h00, 8'hFF);
    check_release("t2_rel", 8'h00, 8'hFF);

    // Short low glitch in WAIT_SYNC must not start a byte
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(20);
    check("glitch_en", {15'd0, programming_enable}, 16'd0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h77, 1'b1);
    check_pair("glitch_p0", 8'h00, 8'h77);
    check_release("glitch_rel", 8'h00, 8'h77);

    // Length 0 means 256 bytes
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 1'b1);
      check_pair("t256", 8'(i), 8'(i));
    end
    check_release("t256_rel", 8'hFF, 8'hFF);

    // Framing error mid-load aborts
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h10, 1'b1);
    check_pair("ferr_p0", 8'h00, 8'h10);
    send_byte(8'h55, 1'b0);
    check("ferr_en",   {15'd0, programming_enable}, 16'd0);
    check("ferr_err",  {15'd0, load_error},         16'd1);
    check("ferr_done", {15'd0, load_done},          16'd0);
    uart_rx = 1'b1;
    tick(10);
    check("ferr_err_sticky", {15'd0, load_error}, 16'd1);
    send_byte(8'hA5, 1'b1);
    check("sync_clears_err", {15'd0, load_error}, 16'd0);

    // Idle gap timeout: abort exactly 200 cycles after the last pair appears
    send_byte(8'h02, 1'b1);
    send_byte(8'h10, 1'b1);
    check_pair("to_p0", 8'h00, 8'h10);
    tick(199);
    check("to_en_before", {15'd0, programming_enable}, 16'd1);
    check("to_err_before", {15'd0, load_error},        16'd0);
    tick(1);
    check("to_en_after",  {15'd0, programming_enable}, 16'd0);
    check("to_err_after", {15'd0, load_error},         16'd1);
    check("to_done",      {15'd0, load_done},          16'd0);

    // Asynchronous reset mid-byte during LOAD
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h10, 1'b1);
    check_pair("arst_p0", 8'h00, 8'h10);
    uart_rx = 1'b0;
    tick(20);
    check("arst_en_pre", {15'd0, programming_enable}, 16'd1);
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_en",   {15'd0, programming_enable}, 16'd0);
    check("arst_addr", {8'd0, ProgrammingAddress},  16'd0);
    check("arst_data", {8'd0, ProgrammingData},     16'd0);
    check("arst_done", {15'd0, load_done},          16'd0);
    check("arst_err",  {15'd0, load_error},         16'd0);
    @(posedge clk);
    #1;
    uart_rx = 1'b1;
    rst_in  = 1'b0;
    tick(5);
    check("arst_en_after", {15'd0, programming_enable}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
